// File: rtl/mc_sync_fifo_if.sv
// Handshake and status bundle for mc_sync_fifo.
// Every field is C channels wide; multi-bit fields pack channel c at [c*width +: width].
interface mc_sync_fifo_if #(
  parameter int W = 32,
  parameter int N = 16,
  parameter int C = 4
);
  localparam int LW = $clog2(N) + 1;

  logic [C-1:0]    push;
  logic [C*W-1:0]  push_data;
  logic [C-1:0]    pop;
  logic [C*W-1:0]  pop_data;
  logic [C-1:0]    flush;
  logic [C-1:0]    empty;
  logic [C-1:0]    full;
  logic [C-1:0]    almost_full;
  logic [C*LW-1:0] level;
  logic [C-1:0]    err_ovf;
  logic [C-1:0]    err_udf;
  logic            err_clr;

  modport master (
    output push, push_data, pop, flush, err_clr,
    input  pop_data, empty, full, almost_full, level, err_ovf, err_udf
  );

  modport slave (
    input  push, push_data, pop, flush, err_clr,
    output pop_data, empty, full, almost_full, level, err_ovf, err_udf
  );
endinterface

// File: rtl/mc_sync_fifo.sv
// Multi-channel single-clock FIFO: C independent depth-N queues sharing one flop array,
// with fall-through head data, occupancy, almost-full, per-channel flush and sticky errors.
module mc_sync_fifo #(
  parameter int W         = 32,
  parameter int N         = 16,
  parameter int C         = 4,
  parameter int AF_THRESH = 12
) (
  input  logic           clk,
  input  logic           rst,
  mc_sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(N);
  localparam int PW = AW + 1;
  localparam int IW = (C * N > 1) ? $clog2(C * N) : 1;

  // Channel c owns entries c*N .. c*N+N-1; storage is deliberately not reset.
  logic [W-1:0]    mem_q [C*N];
  logic [C-1:0]    push_acc;
  logic [C*IW-1:0] wr_addr;

  for (genvar gi = 0; gi < C; gi++) begin : g_ch
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          empty_w, full_w;
    logic          push_acc_w, pop_acc_w;
    logic [IW-1:0] rd_addr;

    // Status comes from registered pointers only, never from this cycle's requests.
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_acc_w = bus.push[gi] && !full_w  && !bus.flush[gi];
    assign pop_acc_w  = bus.pop[gi]  && !empty_w && !bus.flush[gi];

    assign push_acc[gi]             = push_acc_w;
    assign wr_addr[gi*IW +: IW]     = IW'(gi * N) + IW'(wr_ptr_q[AW-1:0]);
    assign rd_addr                  = IW'(gi * N) + IW'(rd_ptr_q[AW-1:0]);

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q && !bus.err_clr;
      udf_d    = udf_q && !bus.err_clr;
      if (bus.flush[gi]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + PW'(push_acc_w);
        rd_ptr_d = rd_ptr_q + PW'(pop_acc_w);
        level_d  = level_q + PW'(push_acc_w) - PW'(pop_acc_w);
        // A new error event beats a simultaneous clear.
        if (bus.push[gi] && full_w) ovf_d = 1'b1;
        if (bus.pop[gi] && empty_w) udf_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        ovf_q    <= 1'b0;
        udf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
      end
    end

    assign bus.empty[gi]          = empty_w;
    assign bus.full[gi]           = full_w;
    assign bus.almost_full[gi]    = (level_q >= PW'(AF_THRESH));
    assign bus.level[gi*PW +: PW] = level_q;
    assign bus.err_ovf[gi]        = ovf_q;
    assign bus.err_udf[gi]        = udf_q;
    assign bus.pop_data[gi*W +: W] = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < C; c++) begin
      if (push_acc[c]) begin
        mem_q[wr_addr[c*IW +: IW]] <= bus.push_data[c*W +: W];
      end
    end
  end
endmodule

// File: tb/tb_mc_sync_fifo.sv
// Bench for mc_sync_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mc_sync_fifo;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int C  = 4;
  localparam int AF = 12;
  localparam int LW = $clog2(N) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_sync_fifo_if #(.W(W), .N(N), .C(C)) bus ();

  mc_sync_fifo #(.W(W), .N(N), .C(C), .AF_THRESH(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mq [C][$];
  logic [C-1:0] m_ovf = '0;
  logic [C-1:0] m_udf = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pd(input int c);
    return bus.pop_data[c*W +: W];
  endfunction

  function automatic logic [LW-1:0] lvl(input int c);
    return bus.level[c*LW +: LW];
  endfunction

  // Reference model: each channel is a plain queue, updated from the requests seen at the edge.
  always @(posedge clk or negedge rst) begin
    logic [C-1:0] so;
    logic [C-1:0] su;
    int sz;
    if (!rst) begin
      for (int c = 0; c < C; c++) mq[c].delete();
      m_ovf = '0;
      m_udf = '0;
    end else begin
      so = '0;
      su = '0;
      for (int c = 0; c < C; c++) begin
        sz = mq[c].size();
        if (bus.flush[c]) begin
          mq[c].delete();
        end else begin
          if (bus.push[c] && sz == N) so[c] = 1'b1;
          if (bus.pop[c] && sz == 0)  su[c] = 1'b1;
          if (bus.pop[c] && sz > 0)   void'(mq[c].pop_front());
          if (bus.push[c] && sz < N)  mq[c].push_back(bus.push_data[c*W +: W]);
        end
      end
      m_ovf = so | (m_ovf & ~{C{bus.err_clr}});
      m_udf = su | (m_udf & ~{C{bus.err_clr}});
    end
  end

  always @(negedge clk) begin
    int sz;
    for (int c = 0; c < C; c++) begin
      sz = mq[c].size();
      chk($sformatf("m_level%0d", c), 64'(lvl(c)), 64'(sz));
      chk($sformatf("m_empty%0d", c), 64'(bus.empty[c]), 64'(sz == 0));
      chk($sformatf("m_full%0d", c), 64'(bus.full[c]), 64'(sz == N));
      chk($sformatf("m_af%0d", c), 64'(bus.almost_full[c]), 64'(sz >= AF));
      chk($sformatf("m_ovf%0d", c), 64'(bus.err_ovf[c]), 64'(m_ovf[c]));
      chk($sformatf("m_udf%0d", c), 64'(bus.err_udf[c]), 64'(m_udf[c]));
      if (sz > 0) chk($sformatf("m_data%0d", c), 64'(pd(c)), 64'(mq[c][0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.push    = '0;
    bus.pop     = '0;
    bus.flush   = '0;
    bus.err_clr = 1'b0;
  endtask

  task automatic push1(input int c, input logic [W-1:0] d);
    bus.push[c] = 1'b1;
    bus.push_data[c*W +: W] = d;
  endtask

  initial begin
    int popped;
    bus.push      = '0;
    bus.pop       = '0;
    bus.flush     = '0;
    bus.err_clr   = 1'b0;
    bus.push_data = '0;

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    chk("rst_empty", 64'(bus.empty), 64'h0f);
    chk("rst_full", 64'(bus.full), 64'h0);
    chk("rst_af", 64'(bus.almost_full), 64'h0);
    chk("rst_level", 64'(bus.level), 64'h0);
    chk("rst_ovf", 64'(bus.err_ovf), 64'h0);
    chk("rst_udf", 64'(bus.err_udf), 64'h0);

    // Channel 0: fill to full, then drain in order.
    for (int i = 1; i <= 16; i++) begin
      push1(0, W'(i));
      step();
      chk("ch0_fill_level", 64'(lvl(0)), 64'(i));
      if (i == 11) chk("ch0_af_before", 64'(bus.almost_full[0]), 64'h0);
      if (i == 12) chk("ch0_af_rise", 64'(bus.almost_full[0]), 64'h1);
    end
    chk("ch0_full", 64'(bus.full[0]), 64'h1);
    for (int i = 1; i <= 16; i++) begin
      chk("ch0_pop_data", 64'(pd(0)), 64'(i));
      bus.pop[0] = 1'b1;
      step();
    end
    chk("ch0_drained", 64'(bus.empty[0]), 64'h1);

    // Channel 1: full, push+pop together drops the push.
    for (int i = 0; i < 16; i++) begin
      push1(1, W'(32'h100 + i));
      step();
    end
    chk("ch1_full", 64'(bus.full[1]), 64'h1);
    push1(1, W'(32'hDEAD));
    bus.pop[1] = 1'b1;
    step();
    chk("ch1_ovf_level", 64'(lvl(1)), 64'd15);
    chk("ch1_ovf_set", 64'(bus.err_ovf[1]), 64'h1);
    chk("ch1_ovf_head", 64'(pd(1)), 64'h101);
    bus.err_clr = 1'b1;
    step();
    chk("ch1_ovf_clr", 64'(bus.err_ovf[1]), 64'h0);

    // Channel 2: pop on empty with a push in the same cycle.
    push1(2, W'(32'hA5));
    bus.pop[2] = 1'b1;
    step();
    chk("ch2_udf_set", 64'(bus.err_udf[2]), 64'h1);
    chk("ch2_udf_level", 64'(lvl(2)), 64'd1);
    chk("ch2_udf_data", 64'(pd(2)), 64'hA5);

    // Channel 3: 40 entries through a shallow window, crossing the pointer wrap twice.
    popped = 0;
    for (int k = 0; k < 3; k++) begin
      push1(3, W'(32'h3000 + k));
      step();
    end
    for (int k = 3; k < 40; k++) begin
      chk("ch3_wrap_data", 64'(pd(3)), 64'(32'h3000 + popped));
      push1(3, W'(32'h3000 + k));
      bus.pop[3] = 1'b1;
      step();
      popped++;
      chk("ch3_wrap_level", 64'(lvl(3)), 64'd3);
    end
    for (int k = 0; k < 3; k++) begin
      chk("ch3_tail_data", 64'(pd(3)), 64'(32'h3000 + popped));
      bus.pop[3] = 1'b1;
      step();
      popped++;
    end
    chk("ch3_empty", 64'(bus.empty[3]), 64'h1);
    chk("ch1_untouched", 64'(lvl(1)), 64'd15);
    chk("ch2_untouched", 64'(pd(2)), 64'hA5);

    // Channel 0: flush beats a simultaneous push.
    for (int i = 0; i < 7; i++) begin
      push1(0, W'(32'h700 + i));
      step();
    end
    chk("ch0_seven", 64'(lvl(0)), 64'd7);
    push1(0, W'(32'hBEEF));
    bus.flush[0] = 1'b1;
    step();
    chk("flush_level", 64'(lvl(0)), 64'd0);
    chk("flush_empty", 64'(bus.empty[0]), 64'h1);
    chk("flush_no_ovf", 64'(bus.err_ovf[0]), 64'h0);
    chk("flush_no_udf", 64'(bus.err_udf[0]), 64'h0);
    chk("flush_ch1_kept", 64'(lvl(1)), 64'd15);

    // Asynchronous reset in the middle of a burst on every channel.
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < C; c++) push1(c, W'(32'h9000 + 16 * c + i));
      step();
    end
    for (int c = 0; c < C; c++) push1(c, W'(32'h9100 + c));
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", 64'(bus.empty), 64'h0f);
    chk("arst_full", 64'(bus.full), 64'h0);
    chk("arst_af", 64'(bus.almost_full), 64'h0);
    chk("arst_level", 64'(bus.level), 64'h0);
    chk("arst_ovf", 64'(bus.err_ovf), 64'h0);
    chk("arst_udf", 64'(bus.err_udf), 64'h0);
    bus.push = '0;
    #10 rst = 1'b1;
    step();
    step();
    chk("post_rst_empty", 64'(bus.empty), 64'h0f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_sync_fifo.md
Name: mc_sync_fifo

Overview:
- Parametrised multi-channel, single-clock FIFO: C independent channels, each a depth-N, width-W queue, built from one flop-based storage array partitioned per channel.
- Successor to the dual-clock FIFO for same-domain buffering, e.g. per-VC queues in front of an arbiter.
- Adds functions the dual-clock FIFO lacks: occupancy count, programmable almost-full, per-channel flush, and sticky overflow/underflow error flags.
- Head data is fall-through: pop_data is valid combinationally whenever the channel is not empty.

Parameters:
- W, 32, data width in bits (>=1).
- N, 16, per-channel depth in entries (power of two, >=2).
- C, 4, number of channels (>=1).
- AF_THRESH, 12, almost_full asserts when level >= AF_THRESH (1..N).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0; deassertion synchronised externally).
- push  in  C  per-channel push request.
- push_data  in  C*W  channel c data in bits [c*W +: W].
- pop  in  C  per-channel pop request.
- pop_data  out  C*W  head entry of channel c in bits [c*W +: W].
- flush  in  C  per-channel synchronous flush.
- empty  out  C  channel level == 0.
- full  out  C  channel level == N.
- almost_full  out  C  channel level >= AF_THRESH.
- level  out  C*(clog2(N)+1)  channel occupancy, 0..N.
- err_ovf  out  C  sticky: push seen while full.
- err_udf  out  C  sticky: pop seen while empty.
- err_clr  in  1  clears all err_ovf/err_udf bits.

Behaviour:
- Per-channel state: wr/rd pointers of clog2(N)+1 bits (wrap bit plus index), level counter.
- empty, full and almost_full are decoded from registered state only, with no combinational path from push/pop.
- Reset (rst=0, asynchronous): pointers and levels go to 0, so empty=all 1, full=0, almost_full=0, level=0, err_*=0.
  - Storage is not reset. pop_data is don't-care while empty.
- Push acceptance: push[c] && !full[c] && !flush[c].
  - Data is written at wr index, wr pointer increments modulo 2N.
  - Index wraps N-1 -> 0 and the wrap bit toggles.
- Pop acceptance: pop[c] && !empty[c] && !flush[c].
  - rd pointer increments. pop_data shows the next entry the following cycle.
- Latency: data pushed in cycle t appears on pop_data and empty deasserts in cycle t+1. There is no same-cycle bypass.
- Simultaneous accepted push and pop: level is unchanged and both pointers advance.
- Push while full is dropped, even if pop is accepted in the same cycle. Storage and wr pointer are unchanged, and err_ovf[c] is set.
- Pop while empty is ignored and sets err_udf[c]. A push in the same cycle is still accepted, and level becomes 1.
- level next = level + push_acc - pop_acc, which can never exceed N or go below 0.
- Flush[c] has priority over push/pop on that channel:
  - Pointers and level go to 0 next cycle.
  - push/pop on that channel are discarded and no error bit is set.
  - Other channels are unaffected.
- err_clr clears all sticky bits. An error event in the same cycle as err_clr wins, so the bit stays set.
- Channels are fully independent, with no shared arbitration; storage for channel c occupies entries c*N..c*N+N-1.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
- Reset, then idle: empty=4'b1111, full=0, level=0 on all channels, err_*=0.
- Channel 0:
  - Push 0x1..0x10 on consecutive cycles: level reaches 16, full[0]=1, and almost_full[0] rises the cycle after the 12th push.
  - Then pop 16 times: data 0x1..0x10 comes out in order and empty[0]=1.
- Channel 1 full (level 16):
  - Push 0xDEAD with pop in the same cycle: pop accepted, push dropped, level=15, err_ovf[1]=1.
  - err_clr: bit clears.
- Channel 2 empty:
  - Push 0xA5 and pop in the same cycle: err_udf[2]=1, level=1, next cycle pop_data[2]=0xA5.
- Wrap: on channel 3 push/pop 40 entries with level held between 1 and 5. Data order is preserved across the pointer wrap, and channels 0-2 are untouched.
- Channel 0 holding 7 entries:
  - Assert flush[0] with push[0]: next cycle level=0, empty[0]=1, no error bits set.
  - Assert rst mid-burst on all channels: outputs return to reset values within the same cycle.
